// File: rtl/claw_pkg.sv
// Shared types and default timing constants for the claw machine controller.
package claw_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVE    = 3'd1,
    S_DOWN    = 3'd2,
    S_GRAB    = 3'd3,
    S_RISE    = 3'd4,
    S_RETURN  = 3'd5,
    S_RELEASE = 3'd6
  } state_e;

  localparam int MOVE_CYCLES     = 8;
  localparam int RELEASE_CYCLES  = 2;
  localparam int GUARANTEE_PLAYS = 10;
  localparam int LOSS_W          = 4;

endpackage

// File: rtl/claw_loss_counter.sv
// Consecutive-loss counter; a win seen anywhere in a play (or a guaranteed play)
// resets it when the play finishes, otherwise it counts up and saturates.
module claw_loss_counter #(
  parameter int GUARANTEE_PLAYS = claw_pkg::GUARANTEE_PLAYS,
  parameter int W               = claw_pkg::LOSS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         play_done,
  input  logic         win,
  input  logic         guaranteed,
  output logic [W-1:0] count,
  output logic         guarantee_next
);

  localparam logic [W-1:0] LIMIT = W'(GUARANTEE_PLAYS - 1);

  logic [W-1:0] count_q, count_d;
  logic         win_q, win_d;

  always_comb begin
    count_d = count_q;
    win_d   = win_q | win;
    if (play_done) begin
      win_d = 1'b0;
      if (win_q || win || guaranteed) begin
        count_d = '0;
      end else if (count_q < LIMIT) begin
        count_d = count_q + 1'b1;
      end
    end else if (win) begin
      // A late prize detected between plays must still break the losing streak.
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      win_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      win_q   <= win_d;
    end
  end

  assign count          = count_q;
  assign guarantee_next = (count_q == LIMIT);

endmodule

// File: rtl/claw_machine.sv
// Claw machine play sequencer: coin, timed joystick move, descend, grab, rise,
// return home and release; every GUARANTEE_PLAYS-th losing play grips tight.
module claw_machine #(
  parameter int MOVE_CYCLES     = claw_pkg::MOVE_CYCLES,
  parameter int RELEASE_CYCLES  = claw_pkg::RELEASE_CYCLES,
  parameter int GUARANTEE_PLAYS = claw_pkg::GUARANTEE_PLAYS
) (
  input  logic clk,
  input  logic rst,
  input  logic Coin,
  input  logic Mov_l,
  input  logic Mov_r,
  input  logic Mov_f,
  input  logic Mov_b,
  input  logic Grab,
  input  logic Touch,
  input  logic Top,
  input  logic Origin,
  input  logic Drop,
  output logic Claw_l,
  output logic Claw_r,
  output logic Claw_f,
  output logic Claw_b,
  output logic Return,
  output logic Down,
  output logic Rise,
  output logic Open,
  output logic Tight,
  output logic Loose,
  output logic Release
);

  import claw_pkg::*;

  localparam int MW = $clog2(MOVE_CYCLES + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [MW-1:0]     MOVE_LAST = MW'(MOVE_CYCLES - 1);
  localparam logic [RW-1:0]     REL_LAST  = RW'(RELEASE_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_MAX  = LOSS_W'(GUARANTEE_PLAYS - 1);

  state_e            state_q, state_d;
  logic [MW-1:0]     mtmr_q, mtmr_d;
  logic [RW-1:0]     rtmr_q, rtmr_d;
  logic              guar_q, guar_d;
  logic              play_done;
  logic              guarantee_next;
  logic [LOSS_W-1:0] loss_cnt;
  logic              grip;

  always_comb begin
    state_d   = state_q;
    mtmr_d    = mtmr_q;
    rtmr_d    = rtmr_q;
    guar_d    = guar_q;
    play_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!Coin) begin
          state_d = S_MOVE;
          mtmr_d  = '0;
          guar_d  = guarantee_next;
        end
      end
      S_MOVE: begin
        if (Grab || (mtmr_q == MOVE_LAST)) begin
          state_d = S_DOWN;
        end else begin
          mtmr_d = mtmr_q + 1'b1;
        end
      end
      S_DOWN:   if (Touch) state_d = S_GRAB;
      S_GRAB:   state_d = S_RISE;
      S_RISE:   if (Top) state_d = S_RETURN;
      S_RETURN: begin
        if (Origin) begin
          state_d = S_RELEASE;
          rtmr_d  = '0;
        end
      end
      S_RELEASE: begin
        if (rtmr_q == REL_LAST) begin
          state_d   = S_IDLE;
          play_done = 1'b1;
        end else begin
          rtmr_d = rtmr_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mtmr_q  <= '0;
      rtmr_q  <= '0;
      guar_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mtmr_q  <= mtmr_d;
      rtmr_q  <= rtmr_d;
      guar_q  <= guar_d;
    end
  end

  // Opposing joystick directions cancel rather than fight the motor.
  assign Claw_l = (state_q == S_MOVE) & Mov_l & ~Mov_r;
  assign Claw_r = (state_q == S_MOVE) & Mov_r & ~Mov_l;
  assign Claw_f = (state_q == S_MOVE) & Mov_f & ~Mov_b;
  assign Claw_b = (state_q == S_MOVE) & Mov_b & ~Mov_f;

  assign grip    = (state_q == S_GRAB) | (state_q == S_RISE) | (state_q == S_RETURN);
  assign Tight   = grip & guar_q;
  assign Loose   = grip & ~guar_q;
  assign Down    = (state_q == S_DOWN);
  assign Open    = (state_q == S_DOWN) | (state_q == S_RELEASE);
  assign Rise    = (state_q == S_RISE);
  assign Return  = (state_q == S_RETURN);
  assign Release = (state_q == S_RELEASE);

  claw_loss_counter #(
    .GUARANTEE_PLAYS (GUARANTEE_PLAYS),
    .W               (LOSS_W)
  ) u_loss (
    .clk            (clk),
    .rst            (rst),
    .play_done      (play_done),
    .win            (~Drop),
    .guaranteed     (guar_q),
    .count          (loss_cnt),
    .guarantee_next (guarantee_next)
  );

  a_loss_sat: assert property (@(posedge clk) disable iff (rst) loss_cnt <= LOSS_MAX);

endmodule

// File: tb/tb_claw_machine.sv
// Self-checking bench for claw_machine: directed vector table, corner sequences
// and randomized plays scored against a play-level model of the loss streak.
module tb_claw_machine;

  localparam int MOVE_CYC = 8;
  localparam int GUAR     = 10;

  localparam logic [10:0] P_DOWN = 11'b00000101000;
  localparam logic [10:0] P_RISE = 11'b00000010000;
  localparam logic [10:0] P_RET  = 11'b00001000000;
  localparam logic [10:0] P_REL  = 11'b00000001001;
  localparam logic [10:0] G_T    = 11'b00000000100;
  localparam logic [10:0] G_L    = 11'b00000000010;

  logic clk = 1'b0;
  logic rst, Coin, Mov_l, Mov_r, Mov_f, Mov_b, Grab, Touch, Top, Origin, Drop;
  logic Claw_l, Claw_r, Claw_f, Claw_b, Return, Down, Rise, Open, Tight, Loose, Release;
  logic [10:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  int losses   = 0;
  bit win_flag = 1'b0;

  claw_machine dut (
    .clk(clk), .rst(rst), .Coin(Coin),
    .Mov_l(Mov_l), .Mov_r(Mov_r), .Mov_f(Mov_f), .Mov_b(Mov_b),
    .Grab(Grab), .Touch(Touch), .Top(Top), .Origin(Origin), .Drop(Drop),
    .Claw_l(Claw_l), .Claw_r(Claw_r), .Claw_f(Claw_f), .Claw_b(Claw_b),
    .Return(Return), .Down(Down), .Rise(Rise), .Open(Open),
    .Tight(Tight), .Loose(Loose), .Release(Release)
  );

  always #5 clk = ~clk;

  assign obs = {Claw_l, Claw_r, Claw_f, Claw_b, Return, Down, Rise, Open, Tight, Loose, Release};

  typedef struct packed {
    logic       coin;
    logic [3:0] mov;
    logic       grab;
    logic       touch;
    logic       top;
    logic       origin;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl [16];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    Coin = 1'b1; {Mov_l, Mov_r, Mov_f, Mov_b} = 4'b0000;
    Grab = 1'b0; Touch = 1'b0; Top = 1'b0; Origin = 1'b0; Drop = 1'b1; rst = 1'b0;
  endtask

  function automatic logic [10:0] claw_exp(input logic [3:0] m);
    logic l, r, f, b;
    l = m[3] & ~m[2];
    r = m[2] & ~m[3];
    f = m[1] & ~m[0];
    b = m[0] & ~m[1];
    return {l, r, f, b, 7'b0};
  endfunction

  // Play-level reference: streak bookkeeping from the rules, not the FSM.
  task automatic end_of_play(input bit won, input bit guar);
    if (won || guar) losses = 0;
    else if (losses < GUAR - 1) losses = losses + 1;
    win_flag = 1'b0;
  endtask

  // drop_mode: 0 none, 1 first release cycle, 2 last release cycle, 3 during rise
  task automatic run_play(input string tag, input int grab_at, input int drop_mode);
    bit          guar;
    bit          won;
    logic [10:0] grip;
    logic [3:0]  mv;
    int          exp_down;
    guar     = (losses == GUAR - 1);
    won      = win_flag || (drop_mode != 0);
    grip     = guar ? G_T : G_L;
    exp_down = (grab_at >= 1 && grab_at <= MOVE_CYC) ? grab_at : MOVE_CYC;
    idle_inputs();
    Coin = 1'b0;
    tick();
    check({tag, "_move_entry"}, obs, 11'b0);
    Coin = 1'b1;
    for (int n = 1; n <= MOVE_CYC + 4; n++) begin
      mv = 4'($urandom_range(0, 15));
      {Mov_l, Mov_r, Mov_f, Mov_b} = mv;
      Grab = (n == grab_at);
      tick();
      check({tag, "_move"}, obs, (n < exp_down) ? claw_exp(mv) : P_DOWN);
      if (n >= exp_down) break;
    end
    Grab = 1'b0;
    for (int w = $urandom_range(0, 3); w > 0; w--) begin
      Coin = 1'($urandom_range(0, 1)); Top = 1'($urandom_range(0, 1));
      {Mov_l, Mov_r, Mov_f, Mov_b} = 4'($urandom_range(0, 15));
      tick();
      check({tag, "_down_wait"}, obs, P_DOWN);
    end
    Coin = 1'b1; Top = 1'b0; {Mov_l, Mov_r, Mov_f, Mov_b} = 4'b0000;
    Touch = 1'b1;
    tick();
    check({tag, "_grab"}, obs, grip);
    Touch = 1'b0;
    tick();
    check({tag, "_rise"}, obs, P_RISE | grip);
    for (int r = $urandom_range(1, 3); r > 0; r--) begin
      Touch = 1'($urandom_range(0, 1)); Origin = 1'($urandom_range(0, 1));
      if (drop_mode == 3 && r == 1) Drop = 1'b0;
      tick();
      check({tag, "_rise_hold"}, obs, P_RISE | grip);
      Drop = 1'b1;
    end
    Touch = 1'b0; Origin = 1'b0; Top = 1'b1;
    tick();
    check({tag, "_return"}, obs, P_RET | grip);
    Top = 1'b0;
    for (int k = $urandom_range(0, 2); k > 0; k--) begin
      Touch = 1'($urandom_range(0, 1)); Top = 1'($urandom_range(0, 1));
      tick();
      check({tag, "_return_hold"}, obs, P_RET | grip);
    end
    Touch = 1'b0; Top = 1'b0; Origin = 1'b1;
    tick();
    check({tag, "_release0"}, obs, P_REL);
    Origin = 1'b0;
    if (drop_mode == 1) Drop = 1'b0;
    tick();
    check({tag, "_release1"}, obs, P_REL);
    Drop = (drop_mode == 2) ? 1'b0 : 1'b1;
    tick();
    check({tag, "_idle"}, obs, 11'b0);
    Drop = 1'b1;
    end_of_play(won, guar);
    check({tag, "_loss_cnt"}, 32'(dut.loss_cnt), 32'(losses));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    check("reset_outputs", obs, 11'b0);
    check("reset_loss_cnt", 32'(dut.loss_cnt), 32'd0);
    rst = 1'b0;
    tick();
    check("post_reset_idle", obs, 11'b0);

    tbl[0]  = {1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00000000000};
    tbl[1]  = {1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00010000000};
    tbl[2]  = {1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 11'b01000000000};
    tbl[3]  = {1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00010000000};
    tbl[4]  = {1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00000000000};
    tbl[5]  = {1'b1, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 11'b10100000000};
    tbl[6]  = {1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, P_DOWN};
    tbl[7]  = {1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, P_DOWN};
    tbl[8]  = {1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, G_L};
    tbl[9]  = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, P_RISE | G_L};
    tbl[10] = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, P_RISE | G_L};
    tbl[11] = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, P_RET | G_L};
    tbl[12] = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, P_REL};
    tbl[13] = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, P_REL};
    tbl[14] = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00000000000};
    tbl[15] = {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 11'b00000000000};

    for (int i = 0; i < 16; i++) begin
      Coin = tbl[i].coin;
      {Mov_l, Mov_r, Mov_f, Mov_b} = tbl[i].mov;
      Grab = tbl[i].grab; Touch = tbl[i].touch; Top = tbl[i].top; Origin = tbl[i].origin;
      tick();
      check($sformatf("table_row%0d", i), obs, tbl[i].exp);
    end
    idle_inputs();
    end_of_play(1'b0, 1'b0);
    check("table_loss_cnt", 32'(dut.loss_cnt), 32'(losses));

    run_play("timeout", 0, 0);
    run_play("grab_at_last", MOVE_CYC, 0);
    run_play("drop_win", 3, 1);
    run_play("after_drop", 2, 0);

    run_play("zero_streak", 1, 2);
    for (int p = 1; p <= GUAR + 1; p++) begin
      run_play($sformatf("streak_play%0d", p), $urandom_range(0, 10), 0);
    end

    idle_inputs();
    Drop = 1'b0;
    tick();
    check("idle_drop_outputs", obs, 11'b0);
    check("idle_drop_clears", 32'(dut.loss_cnt), 32'd0);
    Drop = 1'b1;
    losses   = 0;
    win_flag = 1'b1;
    run_play("after_idle_drop", 4, 1);

    for (int p = 0; p < 5; p++) run_play("build_up", $urandom_range(1, 9), 0);
    check("pre_reset_cnt5", 32'(dut.loss_cnt), 32'd5);
    Coin = 1'b0;
    tick();
    Coin = 1'b1; Grab = 1'b1;
    tick();
    Grab = 1'b0; Touch = 1'b1;
    tick();
    Touch = 1'b0;
    tick();
    check("pre_reset_rise", obs, P_RISE | G_L);
    rst = 1'b1;
    tick();
    check("midplay_reset_outputs", obs, 11'b0);
    check("midplay_reset_cnt", 32'(dut.loss_cnt), 32'd0);
    rst = 1'b0; Top = 1'b1; Origin = 1'b1;
    tick();
    check("after_reset_stays_idle", obs, 11'b0);
    idle_inputs();
    losses   = 0;
    win_flag = 1'b0;

    for (int p = 0; p < 25; p++) begin
      int dm;
      dm = ($urandom_range(0, 7) < 2) ? int'($urandom_range(1, 3)) : 0;
      run_play($sformatf("rand%0d", p), $urandom_range(0, 10), dm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
